cache_data_array: RTL and testbench

Parametrised successor to the L2 line-storage array: a single-port, DEPTH x WIDTH line store with byte-masked writes, per-entry valid bits, and a selectable combinational or registered read. It adds a hardware clear engine that sweeps and zeroes every entry, and a live count of valid entries. It sits under L1/L2 cache datapaths as data or tag storage; the cache controller handles all hit/miss policy.

---
 rtl/cache_array_pkg.sv | 22 ++
 rtl/cache_data_array_if.sv | 37 +++
 rtl/cache_clear_fsm.sv | 61 ++++++
 rtl/cache_data_array.sv | 107 ++++++++++
 tb/tb_cache_data_array.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_array_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cache_array_pkg : shared types and sizing helpers for the array |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package cache_array_pkg;

   typedef enum logic [0:0] {
      CA_IDLE  = 1'b0,
      CA_SWEEP = 1'b1
   } ca_state_t;

   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int bytes_per_line(input int width);
      return width / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_data_array_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cache_data_array_if : access/clear bus of the line-storage array |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface cache_data_array_if #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 32
);
   import cache_array_pkg::*;

   localparam int IDX_W = idx_w(DEPTH);
   localparam int NB    = bytes_per_line(WIDTH);

   logic [IDX_W-1:0] index;
   logic             write;
   logic [NB-1:0]    wmask;
   logic [WIDTH-1:0] datain;
   logic [WIDTH-1:0] dataout;
   logic             valid_out;
   logic             clear_req;
   logic             busy;
   logic             clear_done;
   logic [IDX_W:0]   valid_count;

   modport master (
      output index, write, wmask, datain, clear_req,
      input  dataout, valid_out, busy, clear_done, valid_count
   );

   modport slave (
      input  index, write, wmask, datain, clear_req,
      output dataout, valid_out, busy, clear_done, valid_count
   );

endinterface
`default_nettype wire

// File: rtl/cache_clear_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cache_clear_fsm : sweep engine that walks every entry once      |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module cache_clear_fsm
   import cache_array_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int IDX_W = idx_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_req,
   output logic             busy,
   output logic             clear_done,
   output logic             sweep_we,
   output logic [IDX_W-1:0] sweep_ptr
);

   localparam logic [0:0]       c_idle  = CA_IDLE;
   localparam logic [0:0]       c_sweep = CA_SWEEP;
   localparam logic [IDX_W-1:0] c_last  = IDX_W'(DEPTH - 1);

   logic [0:0]       r_state;
   logic [IDX_W-1:0] r_ptr;
   logic             r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
         r_ptr   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_idle: begin
               if (clear_req) begin
                  r_state <= c_sweep;
                  r_ptr   <= '0;
               end
            end
            c_sweep: begin
               r_ptr <= r_ptr + IDX_W'(1);
               if (r_ptr == c_last) begin
                  r_state <= c_idle;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign busy       = (r_state == c_sweep);
   assign sweep_we   = (r_state == c_sweep);
   assign sweep_ptr  = r_ptr;
   assign clear_done = r_done;

endmodule
`default_nettype wire

// File: rtl/cache_data_array.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cache_data_array : byte-masked line store with valid bits,      |
// | valid count and hardware clear sweep.               rev 1.0     |
// +-----------------------------------------------------------------+
module cache_data_array
   import cache_array_pkg::*;
#(
   parameter int WIDTH    = 256,
   parameter int DEPTH    = 32,
   parameter int READ_LAT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   cache_data_array_if.slave  bus
);

   localparam int IDX_W = idx_w(DEPTH);
   localparam int NB    = bytes_per_line(WIDTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [IDX_W:0]   r_count;

   logic             w_busy;
   logic             w_sweep_we;
   logic [IDX_W-1:0] w_ptr;
   logic             w_wr_en;
   logic [WIDTH-1:0] w_rd_data;
   logic             w_rd_valid;

   cache_clear_fsm #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_clear_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_req  (bus.clear_req),
      .busy       (w_busy),
      .clear_done (bus.clear_done),
      .sweep_we   (w_sweep_we),
      .sweep_ptr  (w_ptr)
   );

   // clear_req has priority over a same-cycle write; an empty mask is a no-op
   assign w_wr_en = bus.write & ~bus.clear_req & ~w_busy & (|bus.wmask);

   always_ff @(posedge clk) begin
      if (w_sweep_we) begin
         r_mem[w_ptr] <= '0;
      end else if (w_wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.wmask[b]) begin
               r_mem[bus.index][8*b +: 8] <= bus.datain[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_count <= '0;
      end else if (w_sweep_we) begin
         r_valid[w_ptr] <= 1'b0;
         if (r_valid[w_ptr]) begin
            r_count <= r_count - (IDX_W+1)'(1);
         end
      end else if (w_wr_en) begin
         r_valid[bus.index] <= 1'b1;
         if (!r_valid[bus.index]) begin
            r_count <= r_count + (IDX_W+1)'(1);
         end
      end
   end

   assign w_rd_data       = r_mem[bus.index];
   assign w_rd_valid      = r_valid[bus.index];
   assign bus.busy        = w_busy;
   assign bus.valid_count = r_count;

   generate
      if (READ_LAT == 0) begin : g_comb_read
         assign bus.dataout   = w_busy ? '0 : w_rd_data;
         assign bus.valid_out = w_busy ? 1'b0 : w_rd_valid;
      end else begin : g_reg_read
         logic [WIDTH-1:0] r_dout;
         logic             r_vout;

         // read-first capture; the output gate also covers the first sweep cycle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dout <= '0;
               r_vout <= 1'b0;
            end else begin
               r_dout <= w_busy ? '0 : w_rd_data;
               r_vout <= w_busy ? 1'b0 : w_rd_valid;
            end
         end

         assign bus.dataout   = w_busy ? '0 : r_dout;
         assign bus.valid_out = w_busy ? 1'b0 : r_vout;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cache_data_array.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_cache_data_array : self-checking bench, READ_LAT 0 and 1     |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_cache_data_array;

   localparam int W  = 256;
   localparam int D  = 32;
   localparam int IW = $clog2(D);
   localparam int NB = W / 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [IW-1:0] index;
   logic          write;
   logic [NB-1:0] wmask;
   logic [W-1:0]  datain;
   logic          clear_req;

   cache_data_array_if #(.WIDTH(W), .DEPTH(D)) if0 ();
   cache_data_array_if #(.WIDTH(W), .DEPTH(D)) if1 ();

   assign if0.index = index;  assign if1.index = index;
   assign if0.write = write;  assign if1.write = write;
   assign if0.wmask = wmask;  assign if1.wmask = wmask;
   assign if0.datain = datain; assign if1.datain = datain;
   assign if0.clear_req = clear_req; assign if1.clear_req = clear_req;

   cache_data_array #(.WIDTH(W), .DEPTH(D), .READ_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   cache_data_array #(.WIDTH(W), .DEPTH(D), .READ_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1));

   int n_tests = 0;
   int n_fail  = 0;
   logic started = 1'b0;

   // reference model: contents, known-byte map (memory is not reset), valids
   logic [W-1:0]  m_mem   [D];
   logic [NB-1:0] m_kn    [D];
   logic          m_valid [D];
   int            m_left  = 0;
   logic          m_done  = 1'b0;
   logic [W-1:0]  m_rq    = '0;
   logic [NB-1:0] m_rk    = '1;
   logic          m_rv    = 1'b0;

   function automatic logic [W-1:0] bmask(input logic [NB-1:0] k);
      logic [W-1:0] r;
      r = '0;
      for (int b = 0; b < NB; b++) if (k[b]) r[8*b +: 8] = 8'hFF;
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp, input logic [W-1:0] msk);
      n_tests++;
      if (((act ^ exp) & msk) !== '0) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      chk(name, act, exp, '1);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
         m_left = 0;
         m_done = 1'b0;
         m_rq   = '0;
         m_rk   = '1;
         m_rv   = 1'b0;
      end else begin
         if (m_left > 0) begin
            m_rq = '0; m_rk = '1; m_rv = 1'b0;
         end else begin
            m_rq = m_mem[index]; m_rk = m_kn[index]; m_rv = m_valid[index];
         end
         m_done = 1'b0;
         if (m_left > 0) begin
            m_mem[D - m_left]   = '0;
            m_kn[D - m_left]    = '1;
            m_valid[D - m_left] = 1'b0;
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
         end else if (clear_req) begin
            m_left = D;
         end else if (write && wmask != '0) begin
            for (int b = 0; b < NB; b++) begin
               if (wmask[b]) begin
                  m_mem[index][8*b +: 8] = datain[8*b +: 8];
                  m_kn[index][b] = 1'b1;
               end
            end
            m_valid[index] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         logic bz;
         int   cnt;
         bz  = (m_left > 0);
         cnt = 0;
         for (int i = 0; i < D; i++) cnt += int'(m_valid[i]);
         chk("busy0",  W'(if0.busy), W'(bz), '1);
         chk("busy1",  W'(if1.busy), W'(bz), '1);
         chk("done0",  W'(if0.clear_done), W'(m_done), '1);
         chk("done1",  W'(if1.clear_done), W'(m_done), '1);
         chk("count0", W'(if0.valid_count), W'(cnt), '1);
         chk("count1", W'(if1.valid_count), W'(cnt), '1);
         if (bz) begin
            chk("dout0", if0.dataout, '0, '1);
            chk("dout1", if1.dataout, '0, '1);
            chk("vout0", W'(if0.valid_out), '0, '1);
            chk("vout1", W'(if1.valid_out), '0, '1);
         end else begin
            chk("dout0", if0.dataout, m_mem[index], bmask(m_kn[index]));
            chk("dout1", if1.dataout, m_rq, bmask(m_rk));
            chk("vout0", W'(if0.valid_out), W'(m_valid[index]), '1);
            chk("vout1", W'(if1.valid_out), W'(m_rv), '1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [IW-1:0] idx, input logic [NB-1:0] msk, input logic [W-1:0] dat);
      index = idx; write = 1'b1; wmask = msk; datain = dat;
      tick();
      write = 1'b0; wmask = '0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!if0.clear_done && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_done: clear_done never seen within 100 cycles");
      end
   endtask

   initial begin
      int bc;
      int dc;
      index = 5; write = 1'b0; wmask = '0; datain = '0; clear_req = 1'b0;
      for (int i = 0; i < D; i++) begin
         m_mem[i] = '0; m_kn[i] = '0; m_valid[i] = 1'b0;
      end
      started = 1'b1;
      repeat (3) tick();
      lit("rst_vout0", W'(if0.valid_out), '0);
      lit("rst_count", W'(if0.valid_count), '0);
      lit("rst_busy",  W'(if0.busy), '0);
      lit("rst_dout1", if1.dataout, '0);
      rst_n = 1'b1;
      tick();

      wr(3, '1, {32{8'hA5}});
      lit("wr_dout0",  if0.dataout, {32{8'hA5}});
      lit("wr_vout0",  W'(if0.valid_out), W'(1));
      lit("wr_count",  W'(if0.valid_count), W'(1));
      tick();
      lit("wr_dout1",  if1.dataout, {32{8'hA5}});
      wr(3, '1, {32{8'hA5}});
      lit("rewr_count", W'(if0.valid_count), W'(1));
      wr(3, 32'h1, 256'h3C);
      lit("partial", if0.dataout, {{31{8'hA5}}, 8'h3C});

      for (int i = 0; i < 4; i++) wr(IW'(10 + i), '1, {32{8'(8'h10 + i)}});
      lit("fill_count", W'(if0.valid_count), W'(5));

      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      bc = 0; dc = 0;
      for (int i = 0; i < 50; i++) begin
         if (if0.busy) bc++;
         if (if0.clear_done) dc++;
         if (i == 5) begin
            index = 20; write = 1'b1; wmask = '1; datain = '1;
         end else begin
            write = 1'b0; wmask = '0;
         end
         tick();
      end
      lit("sweep_len",   W'(bc), W'(D));
      lit("sweep_pulse", W'(dc), W'(1));
      lit("sweep_count", W'(if0.valid_count), '0);
      for (int i = 0; i < D; i++) begin
         index = IW'(i);
         tick();
         lit("post_dout0", if0.dataout, '0);
         lit("post_vout0", W'(if0.valid_out), '0);
      end

      index = 7; write = 1'b1; wmask = '1; datain = {32{8'h77}}; clear_req = 1'b1;
      tick();
      write = 1'b0; wmask = '0; clear_req = 1'b0;
      lit("both_busy",  W'(if0.busy), W'(1));
      lit("both_count", W'(if0.valid_count), '0);
      wait_done();
      tick();
      lit("both_vout7", W'(if0.valid_out), '0);

      wr(1, '1, {32{8'h01}});
      wr(2, '1, {32{8'h02}});
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      lit("abort_busy",  W'(if0.busy), '0);
      lit("abort_count", W'(if0.valid_count), '0);
      tick();
      rst_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         if (if0.clear_done || if1.clear_done) dc++;
         tick();
      end
      lit("abort_nodone", W'(dc), '0);
      wr(4, '1, {32{8'h44}});
      index = 4;
      lit("after_vout0",  W'(if0.valid_out), W'(1));
      lit("after_count",  W'(if0.valid_count), W'(1));
      lit("after_dout0",  if0.dataout, {32{8'h44}});

      wr(9, '1, {32{8'h11}});
      wr(9, '1, {32{8'h22}});
      lit("rl1_old", if1.dataout, {32{8'h11}});
      tick();
      lit("rl1_new", if1.dataout, {32{8'h22}});
      tick();

      started = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
